// File: rtl/sync_fifo_param_if.sv
// Handshake, data and status bundle for sync_fifo_param.
// master drives requests and write data; slave is the FIFO itself.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] dataIn;
  logic             writeEn;
  logic             readEn;
  logic             clrErr;
  logic [WIDTH-1:0] dataOut;
  logic             dataValid;
  logic [CW-1:0]    count;
  logic             EMPTY;
  logic             FULL;
  logic             ALMOST_EMPTY;
  logic             ALMOST_FULL;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport master (
    output dataIn, writeEn, readEn, clrErr,
    input  dataOut, dataValid, count, EMPTY, FULL,
           ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  dataIn, writeEn, readEn, clrErr,
    output dataOut, dataValid, count, EMPTY, FULL,
           ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, occupancy count, watermark flags
// and sticky overflow/underflow errors. Depth need not be a power of two.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             ovf;
  logic             unf;

  logic is_empty;
  logic is_full;
  logic wr_ok;
  logic rd_ok;
  logic ovf_set;
  logic unf_set;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));

  // A write into a full FIFO is legal only when a read frees the slot in the
  // same cycle; an empty FIFO never lets the write fall through to the read.
  assign rd_ok   = bus.readEn && !is_empty;
  assign wr_ok   = bus.writeEn && (!is_full || bus.readEn);
  assign ovf_set = bus.writeEn && is_full && !bus.readEn;
  assign unf_set = bus.readEn && is_empty;

  // Storage is deliberately left out of reset; the pointers hide stale data.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) begin
      mem[wr_ptr] <= bus.dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      dvalid <= rd_ok;
      if (wr_ok && !rd_ok) begin
        cnt <= cnt + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        cnt <= cnt - 1'b1;
      end
      // A fresh error wins over a coincident clear.
      ovf <= ovf_set || (ovf && !bus.clrErr);
      unf <= unf_set || (unf && !bus.clrErr);
    end
  end

  assign bus.dataOut      = dout;
  assign bus.dataValid    = dvalid;
  assign bus.count        = cnt;
  assign bus.EMPTY        = is_empty;
  assign bus.FULL         = is_full;
  assign bus.ALMOST_FULL  = (int'(cnt) >= AF_LEVEL);
  assign bus.ALMOST_EMPTY = (int'(cnt) <= AE_LEVEL);
  assign bus.OVERFLOW     = ovf;
  assign bus.UNDERFLOW    = unf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic reset = 1'b1;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) f();

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(f)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] sb[$];
  int         mcount;
  logic [7:0] exp_dout;
  logic       exp_dv;
  logic       mov;
  logic       mun;

  // Drive one cycle of stimulus, update the reference model, return after the
  // edge with outputs settled.
  task automatic op(input bit we, input bit re, input logic [7:0] d, input bit clr);
    bit wacc, racc, oset, uset;
    f.writeEn = we;
    f.readEn  = re;
    f.dataIn  = d;
    f.clrErr  = clr;
    racc = re && (mcount > 0);
    wacc = we && ((mcount < 8) || re);
    oset = we && (mcount == 8) && !re;
    uset = re && (mcount == 0);
    @(posedge clk);
    #1;
    if (racc) exp_dout = sb.pop_front();
    exp_dv = racc;
    if (wacc) sb.push_back(d);
    mcount = mcount + int'(wacc) - int'(racc);
    mov = oset || (mov && !clr);
    mun = uset || (mun && !clr);
    f.writeEn = 1'b0;
    f.readEn  = 1'b0;
    f.clrErr  = 1'b0;
  endtask

  task automatic do_reset(input bit we, input bit re);
    reset     = 1'b1;
    f.writeEn = we;
    f.readEn  = re;
    f.dataIn  = 8'hEE;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    f.writeEn = 1'b0;
    f.readEn  = 1'b0;
    sb.delete();
    mcount   = 0;
    exp_dout = 8'h00;
    exp_dv   = 1'b0;
    mov      = 1'b0;
    mun      = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    vectors++;
    if ({f.count, f.EMPTY, f.ALMOST_EMPTY, f.FULL, f.ALMOST_FULL, f.OVERFLOW, f.UNDERFLOW, f.dataValid}
        !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags: cnt=%0d E=%b AE=%b F=%b AF=%b OV=%b UN=%b DV=%b, want cnt=0 E=1 AE=1 rest 0",
               f.count, f.EMPTY, f.ALMOST_EMPTY, f.FULL, f.ALMOST_FULL, f.OVERFLOW, f.UNDERFLOW, f.dataValid);
    end
    vectors++;
    if (f.dataOut !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h want 00", f.dataOut);
    end
  endtask

  task automatic test_fill();
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      op(1'b1, 1'b0, 8'(i), 1'b0);
      vectors++;
      if ({f.count, f.FULL, f.ALMOST_FULL, f.ALMOST_EMPTY, f.EMPTY}
          !== {4'(i), (i == 8), (i >= 6), (i <= 2), 1'b0}) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d F=%b AF=%b AE=%b E=%b", i, f.count, f.FULL, f.ALMOST_FULL,
                 f.ALMOST_EMPTY, f.EMPTY);
      end
    end
    op(1'b1, 1'b0, 8'h99, 1'b0);
    vectors++;
    if ({f.OVERFLOW, f.count, f.FULL} !== {1'b1, 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL fill_overflow: OV=%b cnt=%0d F=%b want OV=1 cnt=8 F=1", f.OVERFLOW, f.count, f.FULL);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      op(1'b0, 1'b1, 8'h00, 1'b0);
      vectors++;
      if ({f.dataValid, f.dataOut, f.count} !== {1'b1, 8'(i), 4'(8 - i)} || f.dataOut !== exp_dout) begin
        errors++;
        $display("FAIL drain_%0d: dv=%b dout=%h cnt=%0d want dv=1 dout=%h cnt=%0d",
                 i, f.dataValid, f.dataOut, f.count, 8'(i), 8 - i);
      end
    end
    vectors++;
    if (f.EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: E=%b want 1", f.EMPTY);
    end
    op(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++;
    if ({f.UNDERFLOW, f.dataValid, f.dataOut} !== {1'b1, 1'b0, 8'h08}) begin
      errors++;
      $display("FAIL drain_underflow: UN=%b dv=%b dout=%h want UN=1 dv=0 dout=08",
               f.UNDERFLOW, f.dataValid, f.dataOut);
    end
    op(1'b0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if ({f.dataValid, f.dataOut, f.UNDERFLOW} !== {1'b0, 8'h08, 1'b1}) begin
      errors++;
      $display("FAIL idle_hold: dv=%b dout=%h UN=%b want dv=0 dout=08 UN=1", f.dataValid, f.dataOut, f.UNDERFLOW);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 1'b1, 8'h00, 1'b0);
      vectors++;
      if (f.dataOut !== 8'(8'h10 + i) || f.dataValid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_pre_%0d: dout=%h dv=%b want %h dv=1", i, f.dataOut, f.dataValid, 8'(8'h10 + i));
      end
    end
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    vectors++;
    if (f.count !== 4'd8 || f.FULL !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full: cnt=%0d F=%b want 8 1", f.count, f.FULL);
    end
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 8'h00, 1'b0);
      vectors++;
      if (f.dataOut !== 8'(8'hA0 + i) || f.dataOut !== exp_dout) begin
        errors++;
        $display("FAIL wrap_rd_%0d: dout=%h want %h", i, f.dataOut, 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    op(1'b1, 1'b1, 8'h55, 1'b0);
    vectors++;
    if ({f.dataValid, f.dataOut, f.count, f.OVERFLOW} !== {1'b1, 8'h30, 4'd8, 1'b0}) begin
      errors++;
      $display("FAIL simul_full: dv=%b dout=%h cnt=%0d OV=%b want 1 30 8 0",
               f.dataValid, f.dataOut, f.count, f.OVERFLOW);
    end
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 8'h00, 1'b0);
      vectors++;
      if (f.dataOut !== exp_dout) begin
        errors++;
        $display("FAIL simul_drain_%0d: dout=%h want %h", i, f.dataOut, exp_dout);
      end
    end
    op(1'b1, 1'b1, 8'h66, 1'b0);
    vectors++;
    if ({f.count, f.UNDERFLOW, f.dataValid} !== {4'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL simul_empty: cnt=%0d UN=%b dv=%b want 1 1 0", f.count, f.UNDERFLOW, f.dataValid);
    end
    op(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++;
    if (f.dataOut !== 8'h66 || f.dataValid !== 1'b1) begin
      errors++;
      $display("FAIL simul_nofall: dout=%h dv=%b want 66 1", f.dataOut, f.dataValid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    op(1'b0, 1'b1, 8'h00, 1'b0);
    op(1'b1, 1'b0, 8'h00, 1'b0);
    do_reset(1'b1, 1'b1);
    vectors++;
    if ({f.count, f.EMPTY, f.dataOut, f.dataValid, f.OVERFLOW, f.UNDERFLOW}
        !== {4'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid: cnt=%0d E=%b dout=%h dv=%b OV=%b UN=%b want 0 1 00 0 0 0",
               f.count, f.EMPTY, f.dataOut, f.dataValid, f.OVERFLOW, f.UNDERFLOW);
    end
    op(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++;
    if ({f.UNDERFLOW, f.dataValid, f.dataOut} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rstmid_read: UN=%b dv=%b dout=%h want 1 0 00", f.UNDERFLOW, f.dataValid, f.dataOut);
    end
    op(1'b1, 1'b0, 8'h77, 1'b0);
    op(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++;
    if (f.dataOut !== 8'h77) begin
      errors++;
      $display("FAIL rstmid_stale: dout=%h want 77", f.dataOut);
    end
  endtask

  task automatic test_err_clear();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(i), 1'b0);
    op(1'b1, 1'b0, 8'hF0, 1'b0);
    op(1'b0, 1'b0, 8'h00, 1'b1);
    vectors++;
    if (f.OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL errclr: OV=%b want 0", f.OVERFLOW);
    end
    op(1'b1, 1'b0, 8'hF1, 1'b1);
    vectors++;
    if (f.OVERFLOW !== 1'b1 || f.count !== 4'd8) begin
      errors++;
      $display("FAIL errclr_coincide: OV=%b cnt=%0d want 1 8", f.OVERFLOW, f.count);
    end
    op(1'b0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (f.OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL errclr_sticky: OV=%b want 1", f.OVERFLOW);
    end
  endtask

  task automatic test_random();
    do_reset(1'b0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) == 0));
      vectors++;
      if ({f.dataValid, f.count, f.OVERFLOW, f.UNDERFLOW} !== {exp_dv, 4'(mcount), mov, mun}
          || f.dataOut !== exp_dout
          || {f.EMPTY, f.FULL, f.ALMOST_EMPTY, f.ALMOST_FULL}
             !== {(mcount == 0), (mcount == 8), (mcount <= 2), (mcount >= 6)}) begin
        errors++;
        $display("FAIL random_%0d: dv=%b dout=%h cnt=%0d OV=%b UN=%b want dv=%b dout=%h cnt=%0d OV=%b UN=%b",
                 n, f.dataValid, f.dataOut, f.count, f.OVERFLOW, f.UNDERFLOW,
                 exp_dv, exp_dout, mcount, mov, mun);
      end
    end
  endtask

  initial begin
    f.writeEn = 1'b0;
    f.readEn  = 1'b0;
    f.clrErr  = 1'b0;
    f.dataIn  = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_err_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
